ra_wbq: RTL and testbench

- Write-back queue: the writer side of the 4-entry register array.
- Buffers results from the execute stage and drains them, one per cycle and in order, onto the array's single write port (we/wad/wd).
- Exposes read-port forwarding of pending results, a per-register busy scoreboard, and full/empty status so the datapath can stall.

---
 rtl/ra_wbq.sv | 106 ++++++++++
 tb/tb_ra_wbq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_wbq.sv
// Write-back queue feeding the register array's single write port.
// Holds pending results in order and exposes forwarding, busy scoreboard and status.
module ra_wbq #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_ad,
    input  logic [DW-1:0]            in_d,
    input  logic                     drain_en,
    output logic                     we,
    output logic [AW-1:0]            wad,
    output logic [DW-1:0]            wd,
    input  logic [AW-1:0]            arad,
    input  logic [AW-1:0]            brad,
    output logic                     a_hit,
    output logic [DW-1:0]            a_fwd,
    output logic                     b_hit,
    output logic [DW-1:0]            b_fwd,
    output logic [(2**AW)-1:0]       busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW:0] PTR_ONE = CW'(1);

    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;
    logic [PW-1:0]  wr_idx;
    logic [PW-1:0]  rd_idx;
    logic           push;
    logic           pop;

    logic [AW-1:0]  ent_ad [DEPTH];
    logic [DW-1:0]  ent_d  [DEPTH];

    assign wr_idx = wr_ptr[PW-1:0];
    assign rd_idx = rd_ptr[PW-1:0];

    // Extra wrap bit keeps full and empty distinguishable when indices match.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_idx == rd_idx) && (wr_ptr[PW] != rd_ptr[PW]);
    assign in_ready = !full;

    assign push = in_valid && in_ready;
    assign pop  = !empty && drain_en;

    assign we  = pop;
    assign wad = empty ? '0 : ent_ad[rd_idx];
    assign wd  = empty ? '0 : ent_d[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_ad[wr_idx] <= in_ad;
            ent_d[wr_idx]  <= in_d;
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        a_hit = 1'b0;
        a_fwd = '0;
        b_hit = 1'b0;
        b_fwd = '0;
        busy  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_idx + PW'(i);
            if (CW'(i) < count) begin
                busy[ent_ad[idx]] = 1'b1;
                if (ent_ad[idx] == arad) begin
                    a_hit = 1'b1;
                    a_fwd = ent_d[idx];
                end
                if (ent_ad[idx] == brad) begin
                    b_hit = 1'b1;
                    b_fwd = ent_d[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_ra_wbq.sv
// Bench for ra_wbq: fixed vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_ra_wbq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ad;
    logic [15:0] in_d;
    logic        drain_en;
    logic        we;
    logic [1:0]  wad;
    logic [15:0] wd;
    logic [1:0]  arad;
    logic [1:0]  brad;
    logic        a_hit;
    logic [15:0] a_fwd;
    logic        b_hit;
    logic [15:0] b_fwd;
    logic [3:0]  busy;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    ra_wbq #(.DW(16), .AW(2), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ad    (in_ad),
        .in_d     (in_d),
        .drain_en (drain_en),
        .we       (we),
        .wad      (wad),
        .wd       (wd),
        .arad     (arad),
        .brad     (brad),
        .a_hit    (a_hit),
        .a_fwd    (a_fwd),
        .b_hit    (b_hit),
        .b_fwd    (b_fwd),
        .busy     (busy),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ad;
        logic [15:0] d;
    } ent_t;

    ent_t q[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [1:0]  ad;
        logic [15:0] d;
        logic        dr;
        logic [1:0]  ra;
        logic [1:0]  rb;
        logic        e_we;
        logic [1:0]  e_wad;
        logic [15:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_ah;
        logic [15:0] e_af;
        logic        e_bh;
        logic [15:0] e_bf;
        logic [3:0]  e_busy;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] ad, input logic [15:0] d,
                         input logic dr, input logic [1:0] ra, input logic [1:0] rb);
        in_valid = v;
        in_ad    = ad;
        in_d     = d;
        drain_en = dr;
        arad     = ra;
        brad     = rb;
        #1;
    endtask

    // Advance one clock edge, applying the queue rules to the model first.
    task automatic tick();
        bit do_pop;
        bit do_push;
        if (!rst) begin
            do_pop  = drain_en && (q.size() > 0);
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{ad: in_ad, d: in_d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic        e_ah;
        logic        e_bh;
        logic [15:0] e_af;
        logic [15:0] e_bf;
        logic [3:0]  e_busy;
        logic        has;
        if (rst) q.delete();
        e_ah = 1'b0; e_bh = 1'b0; e_af = '0; e_bf = '0; e_busy = '0;
        has = (q.size() > 0);
        foreach (q[i]) begin
            e_busy[q[i].ad] = 1'b1;
            if (q[i].ad == arad) begin e_ah = 1'b1; e_af = q[i].d; end
            if (q[i].ad == brad) begin e_bh = 1'b1; e_bf = q[i].d; end
        end
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(!has));
        chk({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
        chk({tag, "_we"}, 32'(we), 32'(has && drain_en));
        chk({tag, "_wad"}, 32'(wad), has ? 32'(q[0].ad) : 32'd0);
        chk({tag, "_wd"}, 32'(wd), has ? 32'(q[0].d) : 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
        chk({tag, "_a_hit"}, 32'(a_hit), 32'(e_ah));
        chk({tag, "_a_fwd"}, 32'(a_fwd), 32'(e_af));
        chk({tag, "_b_hit"}, 32'(b_hit), 32'(e_bh));
        chk({tag, "_b_fwd"}, 32'(b_fwd), 32'(e_bf));
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'd2, 16'h1234, 1'b0, 2'd2, 2'd0,
                   1'b0, 2'd0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0000};
        tbl[1] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 2'd0,
                   1'b1, 2'd2, 16'h1234, 3'd1, 1'b1, 16'h1234, 1'b0, 16'h0000, 4'b0100};
        tbl[2] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 2'd0,
                   1'b0, 2'd0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0000};
        tbl[3] = '{1'b1, 2'd1, 16'h0011, 1'b0, 2'd1, 2'd1,
                   1'b0, 2'd0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0000};
        tbl[4] = '{1'b1, 2'd1, 16'h0022, 1'b0, 2'd1, 2'd1,
                   1'b0, 2'd1, 16'h0011, 3'd1, 1'b1, 16'h0011, 1'b1, 16'h0011, 4'b0010};
        tbl[5] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 2'd1,
                   1'b0, 2'd1, 16'h0011, 3'd2, 1'b1, 16'h0022, 1'b1, 16'h0022, 4'b0010};
        tbl[6] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd1,
                   1'b1, 2'd1, 16'h0011, 3'd2, 1'b1, 16'h0022, 1'b1, 16'h0022, 4'b0010};
        tbl[7] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd1,
                   1'b1, 2'd1, 16'h0022, 3'd1, 1'b1, 16'h0022, 1'b1, 16'h0022, 4'b0010};
        tbl[8] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 2'd1,
                   1'b0, 2'd0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0000};

        rst = 1'b1;
        in_valid = 1'b0; in_ad = '0; in_d = '0; drain_en = 1'b0; arad = '0; brad = '0;
        @(posedge clk);
        #1;
        check_model("reset");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table: single write with drain, then two writes to the same register.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].ad, tbl[i].d, tbl[i].dr, tbl[i].ra, tbl[i].rb);
            chk($sformatf("vec%0d_we", i), 32'(we), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d_wad", i), 32'(wad), 32'(tbl[i].e_wad));
            chk($sformatf("vec%0d_wd", i), 32'(wd), 32'(tbl[i].e_wd));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_a_hit", i), 32'(a_hit), 32'(tbl[i].e_ah));
            chk($sformatf("vec%0d_a_fwd", i), 32'(a_fwd), 32'(tbl[i].e_af));
            chk($sformatf("vec%0d_b_hit", i), 32'(b_hit), 32'(tbl[i].e_bh));
            chk($sformatf("vec%0d_b_fwd", i), 32'(b_fwd), 32'(tbl[i].e_bf));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            tick();
        end

        // Fill with drain held off, then an ignored push while full, then drain.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 16'(16'hA000 + i), 1'b0, 2'(i), 2'd3);
            check_model("fill");
            tick();
        end
        drive(1'b1, 2'd3, 16'hBEEF, 1'b0, 2'd3, 2'd0);
        check_model("full_push");
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_a_fwd", 32'(a_fwd), 32'hA003);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 2'd0);
            check_model("drain");
            chk($sformatf("drain%0d_wd", i), 32'(wd), 32'(16'hA000 + i));
            tick();
        end
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 2'd0);
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_we", 32'(we), 32'd0);

        // Hold three pending while pushing and popping every cycle across the wrap.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 1'b0, 2'd0, 2'd1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 1'b1,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            check_model("cc");
            chk($sformatf("cc%0d_count", i), 32'(count), 32'd3);
            tick();
        end

        // Reset mid-cycle while draining three pending entries.
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 2'd0);
        check_model("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        check_model("mid_rst");
        tick();
        check_model("held_rst");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 2'd3, 16'hBEEF, 1'b1, 2'd3, 2'd0);
        check_model("post_rst_push");
        tick();
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 2'd0);
        check_model("post_rst_head");
        chk("post_rst_wd", 32'(wd), 32'hBEEF);
        tick();

        // Randomized run with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                #1;
                check_model("rnd_rst");
                tick();
                rst = 1'b0;
            end else begin
                drive(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
                      1'((i / 40) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                check_model("rnd");
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
